// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions.
//   XLEN           : architectural address width
//   RESET_PC_DEF   : default first fetch address after reset
//   TRAP_VEC_DEF   : default redirect address for a misaligned target
//   fetch_state_e  : PC/fetch controller states
package riscv_pkg;
  localparam int          XLEN         = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    PEND  = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable; shared by performance counters.
//   clk, rst_n : clock, async active-low reset (clears the count)
//   inc_en     : add one this cycle unless already at all-ones
//   count      : current count
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_en && !(&cnt_q)) cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count = cnt_q;
endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC owner and instruction-memory request handshake. Turns a taken
// branch/jump from EX into a PC redirect plus pipeline flushes, and holds a
// request address stable until it is granted.
//   clk, rst_n                 : clock, async active-low reset
//   ex_valid, branch_taken,
//   jump, target               : EX-stage redirect decision and target
//   stall_if                   : hazard unit blocks a new fetch
//   imem_gnt                   : memory accepts current request
//   imem_req, imem_addr, pc    : fetch request, address (= pc), PC register
//   flush_ifid, flush_idex     : squash IF/ID, ID/EX (combinational)
//   misalign_err               : registered pulse after a misaligned redirect
//   redirect_count             : saturating count of accepted redirects
module pc_redirect_ctrl
  import riscv_pkg::*;
#(
  parameter int             XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] TRAP_VEC = TRAP_VEC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            branch_taken,
  input  logic            jump,
  input  logic [XLEN-1:0] target,
  input  logic            stall_if,
  input  logic            imem_gnt,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] pc,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            misalign_err,
  output logic [31:0]     redirect_count
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic            req_wait_q, req_wait_d;   // last cycle's request still ungranted
  logic            misalign_q, misalign_d;

  logic            redir;
  logic            outstanding;
  logic [XLEN-1:0] eff_tgt;

  // BOOT ignores EX, so redir is qualified by state.
  assign redir   = ex_valid & (branch_taken | jump) & (state_q != BOOT);
  assign eff_tgt = (target[1:0] == 2'b00) ? target : TRAP_VEC;

  // The request never depends on redir/gnt, so outstanding has no loop.
  always_comb begin
    imem_req = 1'b0;
    case (state_q)
      FETCH:   imem_req = ~stall_if | req_wait_q;
      PEND:    imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  assign outstanding = imem_req & ~imem_gnt;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redir_pc_d = redir_pc_q;
    req_wait_d = 1'b0;
    misalign_d = redir & (target[1:0] != 2'b00);
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        req_wait_d = outstanding & ~redir;
        if (redir) begin
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          if (outstanding) begin
            // Keep the old address on the bus until its grant arrives.
            redir_pc_d = eff_tgt;
            state_d    = PEND;
          end else begin
            // A same-cycle grant fetched the stale address; flush_ifid kills it.
            pc_d = eff_tgt;
          end
        end else if (imem_req && imem_gnt) begin
          pc_d = pc_q + XLEN'(4);
        end
      end
      PEND: begin
        if (redir) begin
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          if (imem_gnt) begin
            pc_d    = eff_tgt;
            state_d = FETCH;
          end else begin
            redir_pc_d = eff_tgt;   // latest redirect wins
          end
        end else if (imem_gnt) begin
          flush_ifid = 1'b1;        // granted instruction is on the wrong path
          pc_d       = redir_pc_q;
          state_d    = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      redir_pc_q <= '0;
      req_wait_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redir_pc_q <= redir_pc_d;
      req_wait_q <= req_wait_d;
      misalign_q <= misalign_d;
    end
  end

  sat_counter #(.WIDTH(32)) u_redir_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (redir),
    .count  (redirect_count)
  );

  assign pc           = pc_q;
  assign imem_addr    = pc_q;
  assign misalign_err = misalign_q;
endmodule
